mux_nto1_rr: RTL and testbench

Parametrised N:1 data multiplexer with a registered output stage, valid/ready handshaking on every input channel and on the output, and two selection modes: manual (external select) and round-robin (fair scan over requesting channels). It generalises the team's combinational 2:1 data-level mux into a multi-channel, multi-bit, flow-controlled selector. It sits between several producer channels and a single shared consumer.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mux_nto1_rr.sv | 138 +++++++++++++
 tb/tb_mux_nto1_rr.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the N:1 round-robin/manual multiplexer.
//   MODE_MANUAL / MODE_RR : values of the mode input
//   out_state_e           : state of the registered output stage
//   ptr_wrap_inc()        : round-robin pointer increment, wrapping at n-1
// -----------------------------------------------------------------------------
package mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Next pointer after granting idx among n channels; wraps to 0 after n-1.
   function automatic logic [31:0] ptr_wrap_inc(input logic [31:0] idx,
                                                input logic [31:0] n);
      return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority search. Returns the first requesting
// channel found when scanning ptr_i, ptr_i+1, ... modulo CHANNELS.
//   req_i       : per-channel request
//   ptr_i       : highest-priority channel this cycle
//   gnt_valid_o : at least one request present
//   gnt_idx_o   : granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [SEL_W-1:0]    ptr_i,
   output logic                gnt_valid_o,
   output logic [SEL_W-1:0]    gnt_idx_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      // Scan from the farthest offset down to offset 0 so the channel closest
      // to ptr_i is written last and wins.
      for (int off = CHANNELS - 1; off >= 0; off--) begin
         int idx;
         idx = int'(ptr_i) + off;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         for (int j = 0; j < CHANNELS; j++) begin
            if (idx == j && req_i[j]) begin
               gnt_valid_o = 1'b1;
               gnt_idx_o   = SEL_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// mux_nto1_rr
// N:1 data multiplexer with valid/ready on every input channel and a
// registered valid/ready output stage. Channel selection is either manual
// (sel_i) or round-robin over the requesting channels.
//   clk_i        : rising-edge clock
//   rst_i        : synchronous active-high reset
//   mode_i       : 0 = manual, 1 = round-robin
//   sel_i        : manual channel select (out-of-range never grants)
//   in_data_i    : channel i data at [i*WIDTH +: WIDTH]
//   in_valid_i   : per-channel valid
//   in_ready_o   : per-channel ready, at most one bit set (combinational)
//   out_data_o   : registered data
//   out_sel_o    : registered index of the channel that supplied out_data_o
//   out_valid_o  : registered valid
//   out_ready_i  : consumer ready
// -----------------------------------------------------------------------------
module mux_nto1_rr
   import mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      mode_i,
   input  logic [SEL_W-1:0]          sel_i,
   input  logic [CHANNELS*WIDTH-1:0] in_data_i,
   input  logic [CHANNELS-1:0]       in_valid_i,
   output logic [CHANNELS-1:0]       in_ready_o,
   output logic [WIDTH-1:0]          out_data_o,
   output logic [SEL_W-1:0]          out_sel_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i
);

   out_state_e         state_q, state_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [SEL_W-1:0]   out_sel_q, out_sel_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;

   logic               load_en;
   logic               rr_valid, man_valid, gnt_valid;
   logic [SEL_W-1:0]   rr_idx, gnt_idx;
   logic [WIDTH-1:0]   gnt_data;

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_arb (
      .req_i       (in_valid_i),
      .ptr_i       (ptr_q),
      .gnt_valid_o (rr_valid),
      .gnt_idx_o   (rr_idx)
   );

   // The register can accept a word when empty or when the current word
   // leaves this cycle; this is the only out_ready -> in_ready path.
   assign load_en = (state_q == ST_EMPTY) || out_ready_i;

   // Manual grant: compare against each real channel so an out-of-range
   // select simply matches nothing.
   always_comb begin
      man_valid = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel_i == SEL_W'(i) && in_valid_i[i]) man_valid = 1'b1;
      end
   end

   always_comb begin
      if (mode_i == MODE_RR) begin
         gnt_valid = rr_valid;
         gnt_idx   = rr_idx;
      end else begin
         gnt_valid = man_valid;
         gnt_idx   = sel_i;
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (gnt_idx == SEL_W'(i)) gnt_data = in_data_i[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      in_ready_o = '0;
      if (!rst_i && load_en && gnt_valid) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_idx == SEL_W'(i)) in_ready_o[i] = 1'b1;
         end
      end
   end

   // Next-state: a grant while load_en is exactly a transfer, since a grant
   // always implies the granted channel is valid.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_sel_d  = out_sel_q;
      ptr_d      = ptr_q;
      if (load_en) begin
         if (gnt_valid) begin
            state_d    = ST_FULL;
            out_data_d = gnt_data;
            out_sel_d  = gnt_idx;
            if (mode_i == MODE_RR) begin
               ptr_d = SEL_W'(ptr_wrap_inc(32'(gnt_idx), 32'(CHANNELS)));
            end
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_EMPTY;
         out_data_q <= '0;
         out_sel_q  <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_sel_q  <= out_sel_d;
         ptr_q      <= ptr_d;
      end
   end

   assign out_valid_o = (state_q == ST_FULL);
   assign out_data_o  = out_data_q;
   assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_nto1_rr
// Self-checking bench for mux_nto1_rr: single-cycle vector table, hand-written
// multi-cycle sequences, a CHANNELS=3 instance for the out-of-range select,
// and randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mux_nto1_rr;

   localparam int W  = 8;
   localparam int CH = 4;
   localparam int SW = 2;

   logic          clk;
   logic          rst;
   logic          mode;
   logic [SW-1:0] sel;
   logic [CH*W-1:0] in_data;
   logic [CH-1:0] in_valid;
   logic [CH-1:0] in_ready;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_sel;
   logic          out_valid;
   logic          out_ready;

   // Three-channel instance sharing clock, reset, mode and out_ready.
   logic [1:0]    sel3;
   logic [3*W-1:0] in_data3;
   logic [2:0]    in_valid3;
   logic [2:0]    in_ready3;
   logic [W-1:0]  out_data3;
   logic [1:0]    out_sel3;
   logic          out_valid3;

   int checks   = 0;
   int failures = 0;

   mux_nto1_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .mode_i      (mode),
      .sel_i       (sel),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_sel_o   (out_sel),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   mux_nto1_rr #(.WIDTH(W), .CHANNELS(3)) dut3 (
      .clk_i       (clk),
      .rst_i       (rst),
      .mode_i      (mode),
      .sel_i       (sel3),
      .in_data_i   (in_data3),
      .in_valid_i  (in_valid3),
      .in_ready_o  (in_ready3),
      .out_data_o  (out_data3),
      .out_sel_o   (out_sel3),
      .out_valid_o (out_valid3),
      .out_ready_i (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic          mode;
      logic [SW-1:0] sel;
      logic [CH-1:0] valid;
      logic [31:0]   data;
      logic [CH-1:0] exp_ready;
      logic          exp_ov;
      logic [W-1:0]  exp_data;
      logic [SW-1:0] exp_sel;
   } vec_t;

   vec_t vecs[7];

   // Behavioural model state for the random phase.
   int           m_ptr;
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_sel;

   initial begin
      rst       = 1'b1;
      mode      = 1'b0;
      sel       = '0;
      in_data   = '0;
      in_valid  = '0;
      out_ready = 1'b1;
      sel3      = '0;
      in_data3  = '0;
      in_valid3 = '0;

      // Each vector starts from reset (EMPTY, ptr=0) with out_ready=1.
      vecs[0] = '{1'b0, 2'd2, 4'b1111, 32'h3CA5775A, 4'b0100, 1'b1, 8'hA5, 2'd2};
      vecs[1] = '{1'b0, 2'd2, 4'b1011, 32'h3CA5775A, 4'b0000, 1'b0, 8'h00, 2'd0};
      vecs[2] = '{1'b0, 2'd0, 4'b0001, 32'h3CA5775A, 4'b0001, 1'b1, 8'h5A, 2'd0};
      vecs[3] = '{1'b1, 2'd0, 4'b1000, 32'h3CA5775A, 4'b1000, 1'b1, 8'h3C, 2'd3};
      vecs[4] = '{1'b1, 2'd3, 4'b0110, 32'h3CA5775A, 4'b0010, 1'b1, 8'h77, 2'd1};
      vecs[5] = '{1'b1, 2'd0, 4'b0000, 32'h3CA5775A, 4'b0000, 1'b0, 8'h00, 2'd0};
      vecs[6] = '{1'b0, 2'd3, 4'b1000, 32'h3CA5775A, 4'b1000, 1'b1, 8'h3C, 2'd3};

      // ---- Reset with all channels requesting ----
      mode     = 1'b1;
      in_valid = 4'b1111;
      in_data  = 32'h13121110;
      #1;
      check("rst_in_ready_0", 32'(in_ready), 32'h0);
      tick();
      check("rst_in_ready_1", 32'(in_ready), 32'h0);
      tick();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_out_sel", 32'(out_sel), 32'h0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("post_rst_first_sel", 32'(out_sel), 32'h0);

      // ---- Vector table ----
      for (int v = 0; v < 7; v++) begin
         do_reset(1);
         mode      = vecs[v].mode;
         sel       = vecs[v].sel;
         in_valid  = vecs[v].valid;
         in_data   = vecs[v].data;
         out_ready = 1'b1;
         #1;
         check($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_ready));
         tick();
         check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
         check($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_data));
         check($sformatf("vec%0d_out_sel", v), 32'(out_sel), 32'(vecs[v].exp_sel));
      end

      // ---- Round-robin, all channels valid: 0,1,2,3,0,1 with no bubbles ----
      do_reset(1);
      mode     = 1'b1;
      in_valid = 4'b1111;
      in_data  = 32'h13121110;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("rr_all_valid_%0d", k), 32'(out_valid), 32'h1);
         check($sformatf("rr_all_sel_%0d", k), 32'(out_sel), 32'(k % 4));
         check($sformatf("rr_all_data_%0d", k), 32'(out_data), 32'(8'h10 + k % 4));
      end

      // ---- Round-robin with channels 1 and 3: alternates 1,3,1,3 ----
      do_reset(1);
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("rr_1010_sel_%0d", k), 32'(out_sel), (k % 2 == 0) ? 32'd1 : 32'd3);
      end

      // ---- Backpressure while FULL with 8'h3C ----
      do_reset(1);
      in_valid = 4'b0001;
      in_data  = 32'h4433223C;
      tick();
      check("bp_loaded", 32'(out_data), 32'h3C);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
         tick();
         check($sformatf("bp_hold_data_%0d", k), 32'(out_data), 32'h3C);
         check($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'h1);
         check($sformatf("bp_hold_sel_%0d", k), 32'(out_sel), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      // ptr stayed at 1 through the stall, so channel 1 is next.
      check("bp_release_in_ready", 32'(in_ready), 32'h2);
      tick();
      check("bp_release_sel", 32'(out_sel), 32'h1);
      check("bp_release_data", 32'(out_data), 32'h22);

      // ---- Reset mid-stream while FULL ----
      out_ready = 1'b0;
      rst       = 1'b1;
      tick();
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      check("midrst_out_data", 32'(out_data), 32'h0);
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      check("midrst_ptr0_ready", 32'(in_ready), 32'h1);
      tick();
      check("midrst_first_sel", 32'(out_sel), 32'h0);

      // ---- CHANNELS=3: sel=3 never grants, sel=2 does ----
      do_reset(1);
      mode      = 1'b0;
      in_valid3 = 3'b111;
      in_data3  = 24'hC2B1A0;
      sel3      = 2'd3;
      #1;
      check("ch3_sel3_in_ready", 32'(in_ready3), 32'h0);
      tick();
      check("ch3_sel3_out_valid", 32'(out_valid3), 32'h0);
      sel3 = 2'd2;
      #1;
      check("ch3_sel2_in_ready", 32'(in_ready3), 32'h4);
      tick();
      check("ch3_sel2_out_sel", 32'(out_sel3), 32'h2);
      check("ch3_sel2_out_data", 32'(out_data3), 32'hC2);

      // ---- Randomized traffic against the behavioural model ----
      do_reset(1);
      m_ptr   = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      for (int c = 0; c < 400; c++) begin
         logic         load, g;
         int           gi;
         logic [CH-1:0] exp_ready;

         rst       = ($urandom_range(0, 24) == 0);
         mode      = 1'($urandom);
         sel       = SW'($urandom);
         in_valid  = CH'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);

         load = !m_valid || out_ready;
         g    = 1'b0;
         gi   = 0;
         if (mode == 1'b0) begin
            if (int'(sel) < CH && in_valid[sel]) begin
               g  = 1'b1;
               gi = int'(sel);
            end
         end else begin
            for (int off = 0; off < CH && !g; off++) begin
               if (in_valid[(m_ptr + off) % CH]) begin
                  g  = 1'b1;
                  gi = (m_ptr + off) % CH;
               end
            end
         end
         exp_ready = (!rst && load && g) ? CH'(1 << gi) : '0;

         #1;
         check($sformatf("rand%0d_in_ready", c), 32'(in_ready), 32'(exp_ready));
         tick();

         if (rst) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
         end else if (load) begin
            if (g) begin
               m_valid = 1'b1;
               m_data  = W'(in_data >> (gi * W));
               m_sel   = gi;
               if (mode == 1'b1) m_ptr = (gi + 1) % CH;
            end else begin
               m_valid = 1'b0;
            end
         end

         check($sformatf("rand%0d_out_valid", c), 32'(out_valid), 32'(m_valid));
         check($sformatf("rand%0d_out_data", c), 32'(out_data), 32'(m_data));
         check($sformatf("rand%0d_out_sel", c), 32'(out_sel), 32'(m_sel));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
